// File: rtl/rv32_muldiv_seq.sv
// RV32M multiply/divide sequencer: single-cycle 33x33 multiply, iterative restoring divide.
// Holds the pipeline via stall while an op is in flight and returns result + rd for one cycle.
//
//   state | meaning
//   IDLE  | waiting for an M-op from EX
//   MUL   | product computed this cycle, result captured on exit
//   DIV   | restoring divide iterations, counter counts down to 1
//   DONE  | resp_valid asserted for this single cycle
module rv32_muldiv_seq #(
    parameter int XLEN           = 32,
    parameter int DIV_RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd
);

    localparam int N = XLEN / DIV_RADIX_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;

    // op_q[0]=1 marks the unsigned divide variants; for multiplies it encodes the high-half flavour.
    logic        div_signed, neg_a, neg_b;
    logic [31:0] divisor;
    logic [32:0] trial;
    logic [31:0] div_r, div_qt;
    logic [32:0] mul_a, mul_b;
    logic [63:0] prod;

    assign div_signed = ~op_q[0];
    assign neg_a      = div_signed & a_q[31];
    assign neg_b      = div_signed & b_q[31];
    assign divisor    = neg_b ? (32'd0 - b_q) : b_q;

    assign mul_a = {(op_q != 2'b11) & a_q[31], a_q};
    assign mul_b = {(op_q[1] == 1'b0) & b_q[31], b_q};
    assign prod  = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

    always_comb begin
        div_r  = rem_q;
        div_qt = quot_q;
        trial  = '0;
        for (int i = 0; i < DIV_RADIX_BITS; i++) begin
            trial  = {div_r, div_qt[31]};
            div_qt = {div_qt[30:0], 1'b0};
            if (trial >= {1'b0, divisor}) begin
                trial     = trial - {1'b0, divisor};
                div_qt[0] = 1'b1;
            end
            div_r = trial[31:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    op_d = req_funct3[1:0];
                    a_d  = req_rs1;
                    b_d  = req_rs2;
                    rd_d = req_rd;
                    if (!req_funct3[2]) begin
                        state_d = S_MUL;
                    end else if (req_rs2 == 32'd0) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_rd_d    = req_rd;
                        resp_data_d  = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
                    end else if (!req_funct3[0] && req_rs1 == 32'h8000_0000
                                 && req_rs2 == 32'hFFFF_FFFF) begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_rd_d    = req_rd;
                        resp_data_d  = req_funct3[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = 6'(N);
                        rem_d   = 32'd0;
                        quot_d  = (!req_funct3[0] && req_rs1[31]) ? (32'd0 - req_rs1) : req_rs1;
                    end
                end
            end
            S_MUL: begin
                state_d      = S_DONE;
                resp_valid_d = 1'b1;
                resp_rd_d    = rd_q;
                resp_data_d  = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
            end
            S_DIV: begin
                rem_d  = div_r;
                quot_d = div_qt;
                cnt_d  = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    if (op_q[1])
                        resp_data_d = neg_a ? (32'd0 - div_r) : div_r;
                    else
                        resp_data_d = (neg_a ^ neg_b) ? (32'd0 - div_qt) : div_qt;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush kills whatever is in flight and leaves the last result untouched.
        if (flush) begin
            state_d      = S_IDLE;
            cnt_d        = 6'd0;
            resp_valid_d = 1'b0;
            resp_data_d  = resp_data_q;
            resp_rd_d    = resp_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 2'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rd_q         <= 5'd0;
            cnt_q        <= 6'd0;
            rem_q        <= 32'd0;
            quot_q       <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
        end
    end

    assign stall      = (req_valid && state_q == S_IDLE) || state_q == S_MUL || state_q == S_DIV;
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q & ~flush;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;

endmodule

// File: tb/tb_rv32_muldiv_seq.sv
// Directed bench for rv32_muldiv_seq: multiply/divide results, latencies, stall/busy shape,
// special-case divides, flush and mid-op reset.
module tb_rv32_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    int n_checks = 0;
    int n_pass   = 0;

    rv32_muldiv_seq #(.XLEN(32), .DIV_RADIX_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue one op, then follow it to its response, checking result, rd, latency and stall/busy shape.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat);
        int  stall_n;
        int  busy_n;
        int  cyc;
        bit  got;
        req_funct3 = f;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        req_valid  = 1'b1;
        #1;
        stall_n = int'(stall);
        busy_n  = 0;
        tick();
        req_valid = 1'b0;
        req_rs1   = 32'hDEAD_BEEF;
        req_rs2   = 32'h0000_0003;
        req_rd    = 5'd0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            busy_n += int'(busy);
            if (resp_valid) begin
                got = 1'b1;
                chk({tag, " stall_at_resp"}, 32'(stall), 32'd0);
            end else begin
                stall_n += int'(stall);
                tick();
                cyc++;
            end
        end
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        chk({tag, " data"}, resp_data, exp);
        chk({tag, " rd"}, 32'(resp_rd), 32'(rd));
        chk({tag, " stall_cycles"}, 32'(stall_n), 32'(lat));
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(lat));
        tick();
        chk({tag, " resp_pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, " data_held"}, resp_data, exp);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_rs1    = 32'd0;
        req_rs2    = 32'd0;
        req_rd     = 5'd0;
        flush      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_data", resp_data, 32'd0);
        chk("rst resp_rd", 32'(resp_rd), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);

        do_op("MUL 7*-3",     3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 2);
        do_op("MULH -1*-1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 2);
        do_op("MULHSU",       3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 2);
        do_op("MULHU",        3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 2);
        do_op("MULHU big",    3'd3, 32'h8000_0000, 32'h0000_0004, 5'd7,  32'h0000_0002, 2);
        do_op("DIV -7/2",     3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 33);
        do_op("REM -7/2",     3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 33);
        do_op("DIV 7/-2",     3'd4, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
        do_op("REM 7/-2",     3'd6, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'h0000_0001, 33);
        do_op("DIVU 100/7",   3'd5, 32'd100,       32'd7,         5'd12, 32'd14,        33);
        do_op("REMU big",     3'd7, 32'hFFFF_FFFF, 32'd10,        5'd13, 32'd5,         33);
        do_op("DIVU 5/0",     3'd5, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1);
        do_op("REMU 5/0",     3'd7, 32'd5,         32'd0,         5'd15, 32'd5,         1);
        do_op("DIV ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
        do_op("REM ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1);

        // Request together with flush in IDLE is dropped.
        req_funct3 = 3'd0; req_rs1 = 32'd2; req_rs2 = 32'd3; req_rd = 5'd1;
        req_valid = 1'b1; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_accept busy", 32'(busy), 32'd0);

        // Flush on DIV iteration 10.
        req_funct3 = 3'd5; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd20;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_div busy", 32'(busy), 32'd0);
        chk("flush_div resp_valid", 32'(resp_valid), 32'd0);
        chk("flush_div data_kept", resp_data, 32'h0000_0000);
        do_op("MUL after flush", 3'd0, 32'd6, 32'd9, 5'd21, 32'd54, 2);

        // Flush landing on the DONE cycle hides the response.
        req_funct3 = 3'd0; req_rs1 = 32'd5; req_rs2 = 32'd5; req_rd = 5'd22;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("flush_done busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_done resp_valid", 32'(resp_valid), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_done idle", 32'(busy), 32'd0);
        chk("flush_done no_late", 32'(resp_valid), 32'd0);

        // Reset at DIV iteration 5.
        req_funct3 = 3'd4; req_rs1 = 32'd77; req_rs2 = 32'd5; req_rd = 5'd23;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst resp_data", resp_data, 32'd0);
        chk("midrst resp_rd", 32'(resp_rd), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            seen += int'(resp_valid);
            tick();
        end
        chk("midrst no_resp", 32'(seen), 32'd0);
        do_op("DIV after rst", 3'd4, 32'd77, 32'd5, 5'd24, 32'd15, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
